cascade_counter: RTL
====================

CASCADE_COUNTER -- requirements
Module: cascade_counter

Interface
- REQ-001: Parameter DIGITS, default 4: number of cascaded digit stages.
- REQ-002: Parameter BITS, default 4: width of each digit.
- REQ-003: Parameter LIMIT, default 10: modulus of each digit, legal range 2..2**BITS.
- REQ-004: clk  input  1  single clock; all state changes on its rising edge.
- REQ-005: reset  input  1  reset is synchronous and active-low.
- REQ-006: increment  input  1  add one to the least significant digit this cycle.
- REQ-007: decrement  input  1  subtract one from the least significant digit this cycle.
- REQ-008: clear  input  1  set all digits to zero.
- REQ-009: load  input  1  load load_value.
- REQ-010: load_value  input  DIGITS*BITS  packed digits, digit 0 in bits [BITS-1:0].
- REQ-011: value  output  DIGITS*BITS  current count, same packing as load_value.
- REQ-012: overflow  output  1  registered one-cycle pulse on an increment past the maximum count.
- REQ-013: underflow  output  1  registered one-cycle pulse on a decrement below zero.
- REQ-014: zero  output  1  combinational, high when every digit is 0.

Function
- REQ-015: Priority SHALL be reset, then clear, then load, then count.
- REQ-016: Increment SHALL add 1 to digit 0; a digit at LIMIT-1 SHALL go to 0 and carry into the next digit in the same cycle.
- REQ-017: Decrement SHALL subtract 1 from digit 0; a digit at 0 SHALL go to LIMIT-1 and borrow from the next digit in the same cycle.
- REQ-018: increment and decrement both high SHALL leave value unchanged and SHALL not pulse either flag.
- REQ-019: value SHALL reflect the operation at the clock edge at which it is sampled: zero-cycle latency from input sample to register update.
- REQ-020: overflow SHALL be high for exactly the cycle following an edge at which an increment carried out of digit DIGITS-1; otherwise low.
- REQ-021: underflow SHALL be high for exactly the cycle following an edge at which a decrement borrowed out of digit DIGITS-1; otherwise low.
- REQ-022: On load, each loaded digit >= LIMIT SHALL be clamped to LIMIT-1.
- REQ-023: clear or load SHALL take precedence over increment and decrement in the same cycle, and SHALL force both flags low on the next cycle.
- REQ-024: With no operation requested, value SHALL hold and both flags SHALL be low.

Reset
- REQ-025: When reset is low at a rising edge, value SHALL become 0 and overflow and underflow SHALL become 0.
- REQ-026: Reset mid-count SHALL discard any carry, borrow or pending pulse; the first post-reset cycle SHALL show value 0 with both flags low.

Configuration
- REQ-027: Macro CASCADE_COUNTER_SATURATE_EN defined: an increment at maximum (all digits LIMIT-1) SHALL hold value and pulse overflow; a decrement at 0 SHALL hold 0 and pulse underflow.
- REQ-028: Macro undefined: an increment at maximum SHALL wrap to 0 and pulse overflow; a decrement at 0 SHALL wrap to maximum and pulse underflow.

Structure
- REQ-029: Package cascade_counter_pkg SHALL hold the default DIGITS, BITS and LIMIT constants and a typedef for the one-digit type.
- REQ-030: Sub-module counter_digit SHALL implement one digit with carry/borrow in and out; cascade_counter SHALL instantiate DIGITS of them via generate.

Verification
- REQ-031: Defaults; load 0999, then one increment -> value 1000, overflow low, zero low.
- REQ-032: Defaults, macro undefined; load 9999, then increment -> value 0000, overflow high for 1 cycle, zero high.
- REQ-033: Defaults, macro undefined; value 0000, then decrement -> value 9999, underflow high for 1 cycle.
- REQ-034: Macro defined; value 9999, then increment -> value 9999, overflow pulses once. Value 0000, then decrement -> value 0000, underflow pulses once.
- REQ-035: Clamp and collisions:
  - Load digits F,3,C,1 -> value 9391.
  - increment and decrement together at 0500 -> value 0500, no flag pulses.
  - clear and increment together -> 0000.
- REQ-036: Mid-count reset: count to 0042, assert reset low with increment high -> next cycle value 0000, both flags low.

Source files
------------

// File: rtl/cascade_counter_pkg.sv
// Shared defaults and the one-digit type for the cascaded modulo counter.
package cascade_counter_pkg;
  localparam int DIGITS_DEF = 4;
  localparam int BITS_DEF   = 4;
  localparam int LIMIT_DEF  = 10;

  typedef logic [BITS_DEF-1:0] digit_t;
endpackage

// File: rtl/counter_digit.sv
// One modulo-LIMIT digit: ripples carry/borrow combinationally, updates on clk.
module counter_digit
  import cascade_counter_pkg::*;
#(
  parameter int BITS  = BITS_DEF,
  parameter int LIMIT = LIMIT_DEF
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            load_i,
  input  logic [BITS-1:0] load_digit_i,
  input  logic            hold_i,
  input  logic            carry_i,
  input  logic            borrow_i,
  output logic [BITS-1:0] digit_o,
  output logic            carry_o,
  output logic            borrow_o
);
  localparam logic [BITS-1:0] MAXD = BITS'(LIMIT - 1);
  localparam logic [BITS:0]   LIM  = (BITS+1)'(LIMIT);

  logic [BITS-1:0] digit_q, digit_d;

  assign carry_o  = carry_i  && (digit_q == MAXD);
  assign borrow_o = borrow_i && (digit_q == '0);
  assign digit_o  = digit_q;

  always_comb begin
    digit_d = digit_q;
    if (clear_i)
      digit_d = '0;
    else if (load_i)
      digit_d = ({1'b0, load_digit_i} >= LIM) ? MAXD : load_digit_i;
    else if (!hold_i) begin
      // hold_i freezes every digit when a saturating counter hits its bound
      if (carry_i)
        digit_d = (digit_q == MAXD) ? '0 : digit_q + 1'b1;
      else if (borrow_i)
        digit_d = (digit_q == '0) ? MAXD : digit_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) digit_q <= '0;
    else         digit_q <= digit_d;
  end
endmodule

// File: rtl/cascade_counter.sv
// Cascaded DIGITS x modulo-LIMIT up/down counter with clear, clamped load and
// registered overflow/underflow pulses. Define CASCADE_COUNTER_SATURATE_EN to
// hold at the bounds instead of wrapping.
module cascade_counter
  import cascade_counter_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int BITS   = BITS_DEF,
  parameter int LIMIT  = LIMIT_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   increment,
  input  logic                   decrement,
  input  logic                   clear,
  input  logic                   load,
  input  logic [DIGITS*BITS-1:0] load_value,
  output logic [DIGITS*BITS-1:0] value,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   zero
);
  logic [DIGITS:0]                carry, borrow;
  logic [DIGITS-1:0][BITS-1:0]    ld_digits, digits;
  logic                           sat_hold;
  logic                           ovf_q, unf_q;

  // Simultaneous increment and decrement cancel before entering the chain
  assign carry[0]  = increment && !decrement;
  assign borrow[0] = decrement && !increment;
  assign ld_digits = load_value;

`ifdef CASCADE_COUNTER_SATURATE_EN
  assign sat_hold = carry[DIGITS] || borrow[DIGITS];
`else
  assign sat_hold = 1'b0;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    counter_digit #(.BITS(BITS), .LIMIT(LIMIT)) u_digit (
      .clk_i        (clk),
      .rst_ni       (reset),
      .clear_i      (clear),
      .load_i       (load),
      .load_digit_i (ld_digits[g]),
      .hold_i       (sat_hold),
      .carry_i      (carry[g]),
      .borrow_i     (borrow[g]),
      .digit_o      (digits[g]),
      .carry_o      (carry[g+1]),
      .borrow_o     (borrow[g+1])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (clear || load) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= carry[DIGITS];
      unf_q <= borrow[DIGITS];
    end
  end

  assign value     = digits;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign zero      = (digits == '0);
endmodule
